// File: rtl/csi2_frame_sequencer.sv
// CSI-2 frame sequencer: orders FS / NUM_LINES lines / FE through the TX DPHY handshake with gaps.
// Pulses fire one cycle after hs_rdy_i is seen in REQ; c2d_ready_i stalls indefinitely, hs_rdy_i edges time out.
module csi2_frame_sequencer #(
  parameter int NUM_LINES = 240,
  parameter int LINE_GAP  = 16,
  parameter int FRAME_GAP = 64,
  parameter int TIMEOUT   = 1023
) (
  input  logic        byte_clk_i,
  input  logic        reset_byte_n_i,
  input  logic        enable_i,
  input  logic        c2d_ready_i,
  input  logic        hs_rdy_i,
  output logic        txfr_req_o,
  output logic        fv_start_o,
  output logic        line_start_o,
  output logic        fv_end_o,
  output logic [15:0] line_cnt_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_C2D, ST_REQ, ST_ISSUE, ST_WAIT_END, ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    PKT_FS, PKT_LINE, PKT_FE
  } pkt_t;

  localparam logic [15:0] LINE_GAP_M1  = 16'(LINE_GAP - 1);
  localparam logic [15:0] FRAME_GAP_M1 = 16'(FRAME_GAP - 1);
  localparam logic [15:0] NUM_LINES_W  = 16'(NUM_LINES);
  localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT);

  state_t      state_q, state_d;
  pkt_t        pkt_q, pkt_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] line_q, line_d;
  logic [15:0] frame_q, frame_d;
  logic        err_q, err_d;

  always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
    if (!reset_byte_n_i) begin
      state_q <= ST_IDLE;
      pkt_q   <= PKT_FS;
      gap_q   <= 16'd0;
      tmo_q   <= 16'd0;
      line_q  <= 16'd0;
      frame_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    line_d  = line_q;
    frame_d = frame_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_WAIT_C2D;
          pkt_d   = PKT_FS;
        end
      end

      ST_WAIT_C2D: begin
        if (c2d_ready_i) begin
          state_d = ST_REQ;
          tmo_d   = 16'd0;
        end
      end

      // A handshake seen on the timeout cycle still wins over the error.
      ST_REQ: begin
        if (hs_rdy_i) begin
          state_d = ST_ISSUE;
        end else if (tmo_q == TIMEOUT_W) begin
          state_d = ST_IDLE;
          pkt_d   = PKT_FS;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT_END;
        tmo_d   = 16'd0;
        case (pkt_q)
          PKT_FS:   line_d  = 16'd0;
          PKT_LINE: line_d  = line_q + 16'd1;
          PKT_FE:   frame_d = frame_q + 16'd1;
          default:  ;
        endcase
      end

      ST_WAIT_END: begin
        if (!hs_rdy_i) begin
          state_d = ST_GAP;
          gap_d   = (pkt_q == PKT_FE) ? FRAME_GAP_M1 : LINE_GAP_M1;
        end else if (tmo_q == TIMEOUT_W) begin
          state_d = ST_IDLE;
          pkt_d   = PKT_FS;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      // gap_q counts down from gap-1, so the state lasts exactly the gap length.
      ST_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = ST_WAIT_C2D;
          case (pkt_q)
            PKT_FS:   pkt_d = PKT_LINE;
            PKT_LINE: pkt_d = (line_q == NUM_LINES_W) ? PKT_FE : PKT_LINE;
            PKT_FE: begin
              pkt_d = PKT_FS;
              if (!enable_i) state_d = ST_IDLE;
            end
            default: begin
              pkt_d   = PKT_FS;
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pkt_d   = PKT_FS;
      end
    endcase
  end

  assign txfr_req_o   = (state_q == ST_REQ);
  assign fv_start_o   = (state_q == ST_ISSUE) && (pkt_q == PKT_FS);
  assign line_start_o = (state_q == ST_ISSUE) && (pkt_q == PKT_LINE);
  assign fv_end_o     = (state_q == ST_ISSUE) && (pkt_q == PKT_FE);
  assign line_cnt_o   = line_q;
  assign frame_cnt_o  = frame_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_csi2_frame_sequencer.sv
// Bench for csi2_frame_sequencer: acts as the DPHY handshake partner and scoreboards the packet pulses.
module tb_csi2_frame_sequencer;

  localparam int NUM_LINES = 2;
  localparam int LINE_GAP  = 4;
  localparam int FRAME_GAP = 8;
  localparam int TIMEOUT   = 15;

  localparam int K_FS   = 0;
  localparam int K_LINE = 1;
  localparam int K_FE   = 2;

  logic        byte_clk_i;
  logic        reset_byte_n_i;
  logic        enable_i;
  logic        c2d_ready_i;
  logic        hs_rdy_i;
  logic        txfr_req_o;
  logic        fv_start_o;
  logic        line_start_o;
  logic        fv_end_o;
  logic [15:0] line_cnt_o;
  logic [15:0] frame_cnt_o;
  logic        busy_o;
  logic        err_o;

  csi2_frame_sequencer #(
    .NUM_LINES(NUM_LINES),
    .LINE_GAP (LINE_GAP),
    .FRAME_GAP(FRAME_GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .byte_clk_i    (byte_clk_i),
    .reset_byte_n_i(reset_byte_n_i),
    .enable_i      (enable_i),
    .c2d_ready_i   (c2d_ready_i),
    .hs_rdy_i      (hs_rdy_i),
    .txfr_req_o    (txfr_req_o),
    .fv_start_o    (fv_start_o),
    .line_start_o  (line_start_o),
    .fv_end_o      (fv_end_o),
    .line_cnt_o    (line_cnt_o),
    .frame_cnt_o   (frame_cnt_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  // Handshake timing per frame and the resulting cycle distances:
  // lat = pulse - first txfr_req cycle, gaps = next txfr_req - previous pulse.
  typedef struct {
    int rise;
    int fall;
    int lat;
    int gap_line;
    int gap_frame;
  } vec_t;

  vec_t tbl [3];
  int   exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_k;

  initial begin
    byte_clk_i = 1'b0;
    forever #5 byte_clk_i = ~byte_clk_i;
  end

  always @(posedge byte_clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every pulse must match the next queued expectation; a second cycle of the same pulse fails here too.
  always @(negedge byte_clk_i) begin
    if (reset_byte_n_i && (fv_start_o || line_start_o || fv_end_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)",
                 {fv_end_o, line_start_o, fv_start_o}, cyc);
      end else begin
        mon_k = exp_q.pop_front();
        check("pulse_kind", 32'({fv_end_o, line_start_o, fv_start_o}), 32'(1) << mon_k);
      end
    end
  end

  task automatic wait_req(output int t);
    int n;
    t = -1;
    n = 0;
    while (t < 0 && n < 400) begin
      @(negedge byte_clk_i);
      n++;
      if (txfr_req_o) t = cyc;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got no txfr_req_o expected one within %0d cycles", n);
    end
  endtask

  task automatic wait_pulse(output int t);
    int n;
    t = -1;
    n = 0;
    while (t < 0 && n < 100) begin
      @(negedge byte_clk_i);
      n++;
      if (fv_start_o || line_start_o || fv_end_o) t = cyc;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_pulse: got no pulse expected one within %0d cycles", n);
    end
  endtask

  task automatic do_packet(input int kind, input int rise, input int fall, input int exp_lat,
                           input bit chk_gap, input int exp_gap, input int prev_p, output int p);
    int r;
    wait_req(r);
    if (chk_gap) check("gap", 32'(r - prev_p), 32'(exp_gap));
    repeat (rise) @(negedge byte_clk_i);
    hs_rdy_i = 1'b1;
    exp_q.push_back(kind);
    wait_pulse(p);
    check("latency", 32'(p - r), 32'(exp_lat));
    check("req_low_in_issue", 32'(txfr_req_o), 32'(0));
    repeat (fall) @(negedge byte_clk_i);
    hs_rdy_i = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit chk_first, input int first_gap, input int prev_p,
                           input int exp_frames, output int last_p);
    int p0, p1, p2, p3;
    do_packet(K_FS, v.rise, v.fall, v.lat, chk_first, first_gap, prev_p, p0);
    check("line_cnt_fs", 32'(line_cnt_o), 32'(0));
    do_packet(K_LINE, v.rise, v.fall, v.lat, 1'b1, v.gap_line, p0, p1);
    check("line_cnt_l1", 32'(line_cnt_o), 32'(1));
    do_packet(K_LINE, v.rise, v.fall, v.lat, 1'b1, v.gap_line, p1, p2);
    check("line_cnt_l2", 32'(line_cnt_o), 32'(2));
    do_packet(K_FE, v.rise, v.fall, v.lat, 1'b1, v.gap_line, p2, p3);
    check("frame_cnt", 32'(frame_cnt_o), 32'(exp_frames));
    last_p = p3;
  endtask

  initial begin
    int   lp, pa, pb, pc, r, n, q;
    logic seen;

    // Row 2 hits the timeout counter limit in both REQ and WAIT_END on the very cycle the exit occurs.
    tbl[0] = '{rise: 2,  fall: 3,  lat: 3,  gap_line: 9,  gap_frame: 13};
    tbl[1] = '{rise: 0,  fall: 1,  lat: 1,  gap_line: 7,  gap_frame: 11};
    tbl[2] = '{rise: 15, fall: 16, lat: 16, gap_line: 22, gap_frame: 26};

    reset_byte_n_i = 1'b0;
    enable_i       = 1'b1;
    c2d_ready_i    = 1'b1;
    hs_rdy_i       = 1'b0;

    // Reset state with enable already high.
    repeat (3) @(negedge byte_clk_i);
    check("rst_cmds", 32'({txfr_req_o, fv_start_o, line_start_o, fv_end_o}), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_line_cnt", 32'(line_cnt_o), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    reset_byte_n_i = 1'b1;

    // Back-to-back frames driven from the table.
    lp = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i], i > 0, (i > 0) ? tbl[i-1].gap_frame : 0, lp, i + 1, lp);
    end
    check("no_err_at_limit", 32'(err_o), 32'(0));

    // Enable dropped after the first line: frame still completes, then IDLE after FRAME_GAP.
    do_packet(K_FS, 2, 3, 3, 1'b1, tbl[2].gap_frame, lp, pa);
    do_packet(K_LINE, 2, 3, 3, 1'b1, 9, pa, pb);
    enable_i = 1'b0;
    do_packet(K_LINE, 2, 3, 3, 1'b1, 9, pb, pc);
    do_packet(K_FE, 2, 3, 3, 1'b1, 9, pc, lp);
    while (cyc < lp + 3 + FRAME_GAP) @(negedge byte_clk_i);
    check("busy_last_gap", 32'(busy_o), 32'(1));
    @(negedge byte_clk_i);
    check("busy_after_gap", 32'(busy_o), 32'(0));
    repeat (5) @(negedge byte_clk_i);
    check("idle_no_req", 32'({txfr_req_o, busy_o}), 32'(0));
    check("frame_cnt_drop", 32'(frame_cnt_o), 32'(4));

    // c2d gating during a line gap; hs_rdy_i is already high when REQ is entered.
    enable_i = 1'b1;
    do_packet(K_FS, 2, 3, 3, 1'b0, 0, 0, pa);
    c2d_ready_i = 1'b0;
    enable_i    = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge byte_clk_i);
      if (txfr_req_o) seen = 1'b1;
      if (i == 5) hs_rdy_i = 1'b1;
    end
    check("c2d_hold_no_req", 32'(seen), 32'(0));
    check("c2d_hold_busy", 32'(busy_o), 32'(1));
    c2d_ready_i = 1'b1;
    exp_q.push_back(K_LINE);
    @(negedge byte_clk_i);
    check("c2d_resume_req", 32'(txfr_req_o), 32'(1));
    @(negedge byte_clk_i);
    check("hs_early_issue", 32'(line_start_o), 32'(1));
    q = cyc;
    repeat (2) @(negedge byte_clk_i);
    hs_rdy_i = 1'b0;
    do_packet(K_LINE, 2, 3, 3, 1'b1, 8, q, pb);
    do_packet(K_FE, 2, 3, 3, 1'b1, 9, pb, lp);
    check("c2d_no_err", 32'(err_o), 32'(0));
    check("c2d_frame_cnt", 32'(frame_cnt_o), 32'(5));
    repeat (16) @(negedge byte_clk_i);
    check("c2d_idle", 32'(busy_o), 32'(0));

    // hs_rdy_i stuck high after FS: timeout after 16 WAIT_END cycles.
    enable_i = 1'b1;
    wait_req(r);
    repeat (2) @(negedge byte_clk_i);
    hs_rdy_i = 1'b1;
    exp_q.push_back(K_FS);
    wait_pulse(pa);
    enable_i = 1'b0;
    while (cyc < pa + 16) @(negedge byte_clk_i);
    check("we_tmo_busy", 32'({busy_o, err_o}), 32'(2));
    @(negedge byte_clk_i);
    check("we_tmo_err", 32'({busy_o, err_o}), 32'(1));
    hs_rdy_i = 1'b0;
    repeat (5) @(negedge byte_clk_i);
    check("we_tmo_idle", 32'({busy_o, err_o}), 32'(1));

    // Reset pulsed in WAIT_END of line 1.
    enable_i = 1'b1;
    do_packet(K_FS, 2, 3, 3, 1'b0, 0, 0, pa);
    wait_req(r);
    repeat (2) @(negedge byte_clk_i);
    hs_rdy_i = 1'b1;
    exp_q.push_back(K_LINE);
    wait_pulse(pb);
    @(negedge byte_clk_i);
    reset_byte_n_i = 1'b0;
    #1;
    check("mrst_cmds", 32'({txfr_req_o, fv_start_o, line_start_o, fv_end_o, busy_o}), 32'(0));
    check("mrst_cnts", 32'({line_cnt_o, frame_cnt_o}), 32'(0));
    check("mrst_err", 32'(err_o), 32'(0));
    hs_rdy_i = 1'b0;
    repeat (3) @(negedge byte_clk_i);
    check("mrst_hold_busy", 32'(busy_o), 32'(0));
    reset_byte_n_i = 1'b1;
    do_packet(K_FS, 2, 3, 3, 1'b0, 0, 0, pa);
    enable_i = 1'b0;
    do_packet(K_LINE, 2, 3, 3, 1'b1, 9, pa, pb);
    do_packet(K_LINE, 2, 3, 3, 1'b1, 9, pb, pc);
    do_packet(K_FE, 2, 3, 3, 1'b1, 9, pc, lp);
    check("mrst_frame_cnt", 32'(frame_cnt_o), 32'(1));
    repeat (16) @(negedge byte_clk_i);
    check("mrst_idle", 32'(busy_o), 32'(0));

    // hs_rdy_i never rises: 16 cycles of txfr_req_o, then error and IDLE without FE.
    enable_i = 1'b1;
    wait_req(r);
    enable_i = 1'b0;
    check("req_tmo_err_before", 32'(err_o), 32'(0));
    n = 1;
    seen = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (seen) begin
        @(negedge byte_clk_i);
        if (txfr_req_o) n++;
        else seen = 1'b0;
      end
    end
    check("req_tmo_len", 32'(n), 32'(16));
    check("req_tmo_err", 32'({busy_o, err_o}), 32'(1));
    repeat (10) @(negedge byte_clk_i);
    check("req_tmo_idle", 32'({busy_o, txfr_req_o}), 32'(0));
    check("req_tmo_frame_cnt", 32'(frame_cnt_o), 32'(1));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi2_frame_sequencer.md
CSI2_FRAME_SEQUENCER -- requirements
Module: csi2_frame_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 240: long packets (lines) per frame, range 1..65535.
REQ-002 The block SHALL have parameter LINE_GAP, default 16: idle byte clocks after each FS and line packet, range 1..65535.
REQ-003 The block SHALL have parameter FRAME_GAP, default 64: idle byte clocks after each FE packet, range 1..65535.
REQ-004 The block SHALL have parameter TIMEOUT, default 1023: maximum cycles waited for any hs_rdy_i edge, range 1..65535.
REQ-005 The block SHALL have port byte_clk_i, input, 1 bit: byte clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_byte_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable_i, input, 1 bit: permits frame generation.
REQ-008 The block SHALL have port c2d_ready_i, input, 1 bit: TX DPHY clock-to-data ready.
REQ-009 The block SHALL have port hs_rdy_i, input, 1 bit: TX DPHY data-lane HS ready.
REQ-010 The block SHALL have port txfr_req_o, output, 1 bit: transfer request to glue/P2B.
REQ-011 The block SHALL have port fv_start_o, output, 1 bit: 1-cycle FS short-packet command.
REQ-012 The block SHALL have port line_start_o, output, 1 bit: 1-cycle command to the pixel source to emit one line.
REQ-013 The block SHALL have port fv_end_o, output, 1 bit: 1-cycle FE short-packet command.
REQ-014 The block SHALL have port line_cnt_o, output, 16 bits: lines issued in the current frame.
REQ-015 The block SHALL have port frame_cnt_o, output, 16 bits: completed frames.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high when state is not IDLE.
REQ-017 The block SHALL have port err_o, output, 1 bit: sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_C2D, REQ, ISSUE, WAIT_END and GAP, with a 2-bit packet-type register pkt taking values FS, LINE and FE.
REQ-019 IDLE SHALL go to WAIT_C2D with pkt=FS when enable_i=1; otherwise it holds.
REQ-020 WAIT_C2D SHALL go to REQ when c2d_ready_i=1; otherwise it holds indefinitely, with no timeout.
REQ-021 REQ SHALL go to ISSUE when hs_rdy_i=1; txfr_req_o SHALL be 1 only in REQ.
REQ-022 ISSUE SHALL last exactly 1 cycle and then go to WAIT_END; fv_start_o, line_start_o or fv_end_o SHALL be 1 in ISSUE only, as selected by pkt.
REQ-023 Latency: the pulse SHALL appear in the cycle after hs_rdy_i is first sampled high in REQ.
REQ-024 WAIT_END SHALL go to GAP when hs_rdy_i=0; the gap counter SHALL be loaded on that transition.
REQ-025 GAP SHALL last exactly LINE_GAP cycles (pkt FS/LINE) or FRAME_GAP cycles (pkt FE), then transition per REQ-026 to REQ-028.
REQ-026 At GAP end with pkt=FS, the block SHALL set pkt=LINE and go to WAIT_C2D.
REQ-027 At GAP end with pkt=LINE, the block SHALL set pkt=FE if line_cnt_o==NUM_LINES, otherwise keep pkt=LINE, and go to WAIT_C2D.
REQ-028 At GAP end with pkt=FE, the block SHALL set pkt=FS and go to WAIT_C2D if enable_i=1, otherwise go to IDLE.
REQ-029 enable_i deassertion mid-frame SHALL NOT abort the frame; the frame completes through FE and FRAME_GAP.
REQ-030 line_cnt_o SHALL clear to 0 in the FS ISSUE cycle and increment by 1 in each LINE ISSUE cycle; the new value is visible the next cycle.
REQ-031 frame_cnt_o SHALL increment in each FE ISSUE cycle and wrap from 0xFFFF to 0x0000.
REQ-032 A 16-bit timeout counter SHALL clear on entry to REQ and to WAIT_END and increment each cycle the exit condition is false.
REQ-033 When the timeout counter equals TIMEOUT and the exit condition is still false, the block SHALL set err_o=1, go to IDLE next cycle and abandon the frame without issuing FE.
REQ-034 err_o SHALL be cleared only by reset.
REQ-035 Timeout and exit condition true in the same cycle: the exit SHALL win and err_o SHALL remain unchanged.
REQ-036 hs_rdy_i already high on entry to REQ SHALL be accepted; the ISSUE state follows in the next cycle.

Reset
REQ-037 Reset assertion SHALL force, asynchronously, state=IDLE and pkt=FS.
REQ-038 Reset assertion SHALL clear all counters, with line_cnt_o=0, frame_cnt_o=0 and err_o=0.
REQ-039 During reset, txfr_req_o, fv_start_o, line_start_o, fv_end_o and busy_o SHALL be 0.
REQ-040 Reset asserted mid-frame SHALL drop any pulse or request immediately, with no completion of the frame.
REQ-041 After reset release, the block SHALL restart only through IDLE with enable_i=1.

Verification
REQ-042 The bench SHALL use NUM_LINES=2, LINE_GAP=4, FRAME_GAP=8 and TIMEOUT=15.
REQ-043 Scenario, nominal frame: enable_i=1, c2d_ready_i=1, hs_rdy_i rises 2 cycles after each txfr_req_o and falls 3 cycles after each pulse -> pulse order FS, LINE, LINE, FE; 4-cycle gaps after FS and lines, 8-cycle gap after FE; line_cnt_o=2; frame_cnt_o=1.
REQ-044 Scenario, enable drop: enable_i deasserted after the first line_start_o -> second LINE and FE still issued, then IDLE with busy_o=0 and frame_cnt_o=1.
REQ-045 Scenario, REQ timeout: hs_rdy_i held 0 -> txfr_req_o high for 16 cycles, then err_o=1, state IDLE, no fv_end_o.
REQ-046 Scenario, WAIT_END timeout: hs_rdy_i stuck 1 after a pulse -> err_o=1 after 16 cycles in WAIT_END, then IDLE.
REQ-047 Scenario, c2d gating: c2d_ready_i=0 during a line gap -> block holds in WAIT_C2D with txfr_req_o=0, and resumes in the cycle after c2d_ready_i=1 with no err_o.
REQ-048 Scenario, mid-frame reset: reset_byte_n_i pulsed during WAIT_END of line 1 -> all outputs 0 immediately, counters 0, next frame begins with fv_start_o.
